// File: rtl/program_loader_pkg.sv
// Shared types and helpers for the program loader: FSM states, error codes,
// instruction word width and the opcode legality check.
package program_loader_pkg;

    localparam int INSTR_W = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_OPC,
        S_OPA,
        S_OPB,
        S_WRITE,
        S_CHECK,
        S_ERROR
    } LOADER_STATE_T;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'b00,
        ERR_BAD_OPCODE   = 2'b01,
        ERR_BAD_CHECKSUM = 2'b10,
        ERR_TIMEOUT      = 2'b11
    } LOAD_ERR_T;

    // Defined opcodes occupy 0x00..0x1E plus 0xFF.
    function automatic logic is_valid_opcode(input logic [7:0] op);
        return (op <= 8'h1E) || (op == 8'hFF);
    endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// Idle-cycle counter for the loader. Counts enabled cycles, clears on demand,
// and flags the cycle whose increment would reach TIMEOUT_CYCLES.
module loader_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // Terminal count is combinational so the FSM can act on the same edge.
    assign expired = enable && !clear && (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count idle cycles; clear wins over enable.
    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: parses SYNC/COUNT/N x {opc,opA,opB}/CHK frames,
// writes 24-bit instruction words to program memory and stalls the core
// while a frame is in flight.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         ADDR_W         = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               core_hold,
    output logic               load_done,
    output logic               load_err,
    output logic [1:0]         err_code
);

    LOADER_STATE_T     state;
    LOAD_ERR_T         err_q;
    logic [7:0]        n_q;
    logic [7:0]        done_cnt;
    logic [7:0]        chk;
    logic [7:0]        opc_q;
    logic [7:0]        opa_q;
    logic [ADDR_W-1:0] idx;

    logic fire;
    logic timed;
    logic to_hit;

    assign fire     = in_valid && in_ready;
    assign err_code = err_q;

    // Only states waiting on a frame byte are watched for idle time. Clearing
    // outside those states doubles as the reset-on-entry (WRITE->OPC/CHECK).
    assign timed = (state == S_COUNT) || (state == S_OPC) || (state == S_OPA) ||
                   (state == S_OPB) || (state == S_CHECK);

    loader_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (fire || !timed),
        .enable (timed && !fire),
        .expired(to_hit)
    );

    // Frame parser FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            err_q     <= ERR_NONE;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_hold <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            n_q       <= '0;
            done_cnt  <= '0;
            chk       <= '0;
            opc_q     <= '0;
            opa_q     <= '0;
            idx       <= '0;
        end else begin
            mem_we   <= 1'b0;
            in_ready <= 1'b1;
            if (to_hit) begin
                state     <= S_ERROR;
                err_q     <= ERR_TIMEOUT;
                load_err  <= 1'b1;
                core_hold <= 1'b0;
            end else begin
                case (state)
                    // ERROR is IDLE with the sticky error still showing.
                    S_IDLE, S_ERROR: begin
                        if (fire && in_data == SYNC_BYTE) begin
                            state     <= S_COUNT;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                            err_q     <= ERR_NONE;
                            core_hold <= 1'b1;
                            idx       <= '0;
                            done_cnt  <= '0;
                            chk       <= '0;
                        end
                    end
                    S_COUNT: begin
                        if (fire) begin
                            if (in_data == 8'h00) begin
                                state     <= S_ERROR;
                                err_q     <= ERR_TIMEOUT;
                                load_err  <= 1'b1;
                                core_hold <= 1'b0;
                            end else begin
                                n_q   <= in_data;
                                chk   <= chk ^ in_data;
                                state <= S_OPC;
                            end
                        end
                    end
                    S_OPC: begin
                        if (fire) begin
                            if (is_valid_opcode(in_data)) begin
                                opc_q <= in_data;
                                chk   <= chk ^ in_data;
                                state <= S_OPA;
                            end else begin
                                state     <= S_ERROR;
                                err_q     <= ERR_BAD_OPCODE;
                                load_err  <= 1'b1;
                                core_hold <= 1'b0;
                            end
                        end
                    end
                    S_OPA: begin
                        if (fire) begin
                            opa_q <= in_data;
                            chk   <= chk ^ in_data;
                            state <= S_OPB;
                        end
                    end
                    // The write is launched here so mem_we is high during WRITE.
                    S_OPB: begin
                        if (fire) begin
                            chk       <= chk ^ in_data;
                            mem_we    <= 1'b1;
                            mem_addr  <= idx;
                            mem_wdata <= {opc_q, opa_q, in_data};
                            in_ready  <= 1'b0;
                            state     <= S_WRITE;
                        end
                    end
                    // Address wraps with idx; termination uses the 8-bit count.
                    S_WRITE: begin
                        idx      <= idx + ADDR_W'(1);
                        done_cnt <= done_cnt + 8'd1;
                        state    <= (done_cnt + 8'd1 == n_q) ? S_CHECK : S_OPC;
                    end
                    S_CHECK: begin
                        if (fire) begin
                            core_hold <= 1'b0;
                            if (in_data == chk) begin
                                load_done <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                load_err <= 1'b1;
                                err_q    <= ERR_BAD_CHECKSUM;
                                state    <= S_ERROR;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: valid load, bad opcode, bad checksum,
// timeout, zero count, continuous-valid backpressure and mid-frame reset.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [23:0] mem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_err;
    logic [1:0]  err_code;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [23:0] data;
    } wr_t;
    wr_t wq[$];

    program_loader #(
        .ADDR_W(8),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .core_hold(core_hold),
        .load_done(load_done),
        .load_err (load_err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    // Log every memory write strobe seen at a clock edge.
    always @(posedge clk) begin
        if (!rst && mem_we) wq.push_back('{addr: mem_addr, data: mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One byte, one transfer; returns on the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int g = 0;
        @(negedge clk);
        while (!in_ready && g < 10) begin
            g++;
            @(negedge clk);
        end
        if (!in_ready) check("send_ready", {31'd0, in_ready}, 32'd1);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_wr(input string tag, input int k, input logic [7:0] a, input logic [23:0] d);
        if (wq.size() > k) begin
            check({tag, "_addr"}, {24'd0, wq[k].addr}, {24'd0, a});
            check({tag, "_data"}, {8'd0, wq[k].data}, {8'd0, d});
        end else begin
            check({tag, "_missing"}, wq.size(), k + 1);
        end
    endtask

    logic [7:0] bp [0:8] = '{8'hA5, 8'h02, 8'h03, 8'h01, 8'h05, 8'h07, 8'h01, 8'h02, 8'h01};

    initial begin
        int i, stalls, guard;
        int spos[$];

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_core_hold", {31'd0, core_hold}, 32'd0);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_err", {31'd0, load_err}, 32'd0);
        check("rst_code", {30'd0, err_code}, 32'd0);

        // Valid two-instruction frame, CHK = 01
        wq.delete();
        send(8'h33);
        check("idle_discard_hold", {31'd0, core_hold}, 32'd0);
        send(8'hA5);
        check("v_hold_on", {31'd0, core_hold}, 32'd1);
        send(8'h02);
        send(8'h03); send(8'h01); send(8'h05);
        send(8'h07); send(8'h01); send(8'h02);
        check("v_we_pulse", {31'd0, mem_we}, 32'd1);
        check("v_we_addr", {24'd0, mem_addr}, 32'd1);
        check("v_we_data", {8'd0, mem_wdata}, 32'h070102);
        check("v_in_ready_write", {31'd0, in_ready}, 32'd0);
        check("v_hold_before_chk", {31'd0, core_hold}, 32'd1);
        send(8'h01);
        check("v_done", {31'd0, load_done}, 32'd1);
        check("v_hold_off", {31'd0, core_hold}, 32'd0);
        check("v_err", {31'd0, load_err}, 32'd0);
        check("v_nwrites", wq.size(), 2);
        check_wr("v_w0", 0, 8'h00, 24'h030105);
        check_wr("v_w1", 1, 8'h01, 24'h070102);

        // Invalid opcode 0x20
        wq.delete();
        send(8'hA5); send(8'h01); send(8'h20);
        check("op_nwrites", wq.size(), 0);
        check("op_err", {31'd0, load_err}, 32'd1);
        check("op_code", {30'd0, err_code}, 32'd1);
        check("op_hold", {31'd0, core_hold}, 32'd0);
        check("op_done", {31'd0, load_done}, 32'd0);
        // Recovery frame: 01, 03 01 05, CHK = 01^03^01^05 = 06
        send(8'hA5);
        check("rec_err_clr", {31'd0, load_err}, 32'd0);
        check("rec_code_clr", {30'd0, err_code}, 32'd0);
        send(8'h01); send(8'h03); send(8'h01); send(8'h05); send(8'h06);
        check("rec_done", {31'd0, load_done}, 32'd1);
        check("rec_nwrites", wq.size(), 1);
        check_wr("rec_w0", 0, 8'h00, 24'h030105);

        // Bad checksum: writes still land
        wq.delete();
        send(8'hA5); send(8'h02);
        send(8'h03); send(8'h01); send(8'h05);
        send(8'h07); send(8'h01); send(8'h02);
        send(8'h00);
        check("ck_nwrites", wq.size(), 2);
        check_wr("ck_w1", 1, 8'h01, 24'h070102);
        check("ck_err", {31'd0, load_err}, 32'd1);
        check("ck_code", {30'd0, err_code}, 32'd2);
        check("ck_done", {31'd0, load_done}, 32'd0);
        check("ck_hold", {31'd0, core_hold}, 32'd0);

        // Timeout: 15 idle cycles are tolerated, the 16th trips it
        send(8'hA5); send(8'h01); send(8'hFF);
        repeat (15) @(negedge clk);
        check("to_15_code", {30'd0, err_code}, 32'd0);
        check("to_15_hold", {31'd0, core_hold}, 32'd1);
        @(negedge clk);
        check("to_16_code", {30'd0, err_code}, 32'd3);
        check("to_16_err", {31'd0, load_err}, 32'd1);
        check("to_16_hold", {31'd0, core_hold}, 32'd0);

        // Zero count
        send(8'hA5); send(8'h00);
        check("zc_code", {30'd0, err_code}, 32'd3);
        check("zc_err", {31'd0, load_err}, 32'd1);
        check("zc_hold", {31'd0, core_hold}, 32'd0);

        // Continuous valid: in_ready drops once after each OPB byte
        wq.delete();
        i = 0; stalls = 0; guard = 0;
        while (i < 9 && guard < 100) begin
            @(negedge clk);
            guard++;
            in_data  = bp[i];
            in_valid = 1'b1;
            if (in_ready) i++;
            else begin
                stalls++;
                spos.push_back(i);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_all_sent", i, 9);
        check("bp_stalls", stalls, 2);
        check("bp_stall0", spos.size() > 0 ? spos[0] : 99, 5);
        check("bp_stall1", spos.size() > 1 ? spos[1] : 99, 8);
        check("bp_done", {31'd0, load_done}, 32'd1);
        check("bp_nwrites", wq.size(), 2);
        check_wr("bp_w0", 0, 8'h00, 24'h030105);
        check_wr("bp_w1", 1, 8'h01, 24'h070102);

        // Reset after the second instruction byte
        wq.delete();
        send(8'hA5); send(8'h02); send(8'h03); send(8'h01);
        check("rs_hold_pre", {31'd0, core_hold}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rs_in_ready", {31'd0, in_ready}, 32'd1);
        check("rs_hold", {31'd0, core_hold}, 32'd0);
        check("rs_done", {31'd0, load_done}, 32'd0);
        check("rs_err", {31'd0, load_err}, 32'd0);
        check("rs_code", {30'd0, err_code}, 32'd0);
        send(8'h05); send(8'h07); send(8'h01); send(8'h02);
        repeat (3) @(negedge clk);
        check("rs_nwrites", wq.size(), 0);
        check("rs_hold_after", {31'd0, core_hold}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Receives a byte-stream program image and writes decoded 24-bit instruction words (opcode, operand A, operand B) into the core's program memory.
- Sits between a byte source (UART RX or debug bridge) and the program-memory write port.
- Holds the z8 core in FETCH-stall while loading, validates opcodes and checksum, and reports done/error.
- Opposite end of the core's fetch/decode path: it produces what the decoder consumes.

Parameters:
- ADDR_W, 8, program-memory address width.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 100000, maximum idle cycles between bytes inside a frame; must be ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_data  in  8  incoming byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte this cycle (transfer when in_valid && in_ready)
- mem_we  out  1  program-memory write strobe, one cycle
- mem_addr  out  ADDR_W  write address (instruction index)
- mem_wdata  out  24  {opcode[23:16], opA[15:8], opB[7:0]}
- core_hold  out  1  stall core fetch while a frame is in progress
- load_done  out  1  last frame loaded and checksum good (sticky)
- load_err  out  1  last frame failed (sticky)
- err_code  out  2  00 none, 01 bad opcode, 10 bad checksum, 11 timeout/zero count

Behaviour:
- Frame format:
  - SYNC_BYTE, then COUNT N (1..255).
  - N×{opcode, opA, opB}.
  - CHK, where CHK = XOR of COUNT and all instruction bytes.
- States: IDLE, COUNT, OPC, OPA, OPB, WRITE, CHECK, ERROR.
- Reset: state=IDLE. All outputs 0 except in_ready=1. Counters, checksum accumulator and index are 0.
- IDLE:
  - Bytes other than SYNC_BYTE are accepted and discarded.
  - On SYNC_BYTE → COUNT. In the same cycle: clear load_done, load_err and err_code; set core_hold=1; zero the index and checksum.
- COUNT:
  - Byte 0 → ERROR with code 11.
  - Otherwise latch N, checksum ^= byte, → OPC.
- OPC:
  - Opcode is valid iff 0x00..0x1E or 0xFF; otherwise → ERROR with code 01 (byte consumed).
  - Valid opcode: latch it, checksum ^= byte, → OPA.
- OPA, OPB: latch the byte, checksum ^= byte, → next state. After OPB → WRITE.
- WRITE (exactly one cycle):
  - in_ready=0; mem_we=1; mem_addr=index; mem_wdata=latched word.
  - Next: index+1. If index+1==N → CHECK, else → OPC.
  - Memory write latency is therefore 1 cycle after the OPB byte.
- CHECK:
  - Byte == checksum → load_done=1, core_hold=0, → IDLE.
  - Otherwise → load_err=1, err_code=10, → ERROR.
- ERROR:
  - core_hold=0; load_err=1.
  - Behaves as IDLE: next SYNC_BYTE starts a new frame and clears the error.
  - Earlier memory writes from the failed frame are not undone. load_done=0 marks the image invalid.
- Timeout:
  - In COUNT/OPC/OPA/OPB/CHECK, an idle counter increments each cycle with no transfer and clears on any transfer.
  - Reaching TIMEOUT_CYCLES → ERROR, err_code=11.
  - The counter is reset on every state entry.
- in_ready=1 in every state except WRITE.
- Index width ADDR_W. If N > 2^ADDR_W, the address wraps modulo 2^ADDR_W; no error is raised.
- Synchronous rst mid-frame → IDLE immediately, core_hold=0, no further writes. A partially written memory remains.
- A SYNC_BYTE inside a frame is ordinary data; no resync.

Decomposition:
- Add to instruction_set package:
  - LOADER_STATE_T enum (the eight states).
  - LOAD_ERR_T enum (NONE, BAD_OPCODE, BAD_CHECKSUM, TIMEOUT).
  - Constant INSTR_W=24.
  - Function is_valid_opcode(logic[7:0]) returning 1 for defined OPCODES_T values.
- One sub-module: loader_timeout_counter (enable/clear, terminal-count flag, parameterised by TIMEOUT_CYCLES).

Test Plan:
- Valid frame: send A5, 02, 03 01 05, 07 01 02, CHK=02^03^01^05^07^01^02=01.
  - Expect exactly two mem_we pulses: addr 0 data 0x030105, then addr 1 data 0x070102.
  - Expect load_done=1, core_hold 1→0 one cycle after CHK.
- Invalid opcode: A5, 01, 20 → expect no mem_we, load_err=1, err_code=01, core_hold=0. A following valid frame clears the error and loads.
- Bad checksum: same as the first test with CHK=00 → both writes occur, load_err=1, err_code=10, load_done=0.
- Timeout and zero count, with TIMEOUT_CYCLES=16:
  - Send A5, 01, FF then stall 16 cycles → err_code=11.
  - Separately send A5, 00 → err_code=11.
- Backpressure and reset:
  - Hold in_valid=1 continuously → in_ready drops for exactly one cycle after each OPB byte, and no byte is lost.
  - Assert rst after the second instruction byte → outputs return to reset values, no mem_we afterwards.
